// File: rtl/ts_demuxer.sv
// Pseudo-TS receive demuxer: buffers tagged packets whole in two ping-pong banks
// and replays each one gaplessly on its tagged channel with the tag byte restored.
module ts_demuxer #(
  parameter int unsigned PKT_LEN     = 188,
  parameter int unsigned TAG_POS     = 0,
  parameter logic [5:0]  TAG_MAGIC   = 6'h11,
  parameter logic [7:0]  RESTORE_VAL = 8'h47
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  input  logic        P_SYNC_IN,
  input  logic [3:0]  CH_EN,
  output logic [31:0] DATA_OUT,
  output logic [3:0]  D_VALID_OUT,
  output logic [3:0]  P_SYNC_OUT,
  output logic [15:0] DROP_CNT,
  output logic        LOCKED
);

  localparam int unsigned IW = $clog2(PKT_LEN);
  localparam int unsigned AW = $clog2(2 * PKT_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
  localparam logic [IW-1:0] TAG_IDX  = IW'(TAG_POS);

  typedef enum logic {W_HUNT, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_SEND} rd_state_e;

  wr_state_e       wr_state_q, wr_state_d;
  logic            wr_bank_q, wr_bank_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]      tag_q, tag_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][1:0] bank_ch_q, bank_ch_d;
  logic            old_bank_q, old_bank_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  rd_state_e       rd_state_q, rd_state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;

  logic            s1_vld_q, s1_vld_d;
  logic [1:0]      s1_ch_q, s1_ch_d;
  logic            s1_first_q, s1_first_d;
  logic            s1_tag_q, s1_tag_d;
  logic [7:0]      rd_data_q;

  logic [31:0]     data_out_q, data_out_d;
  logic [3:0]      dvalid_q, dvalid_d;
  logic [3:0]      psync_q, psync_d;

  logic [7:0]      mem_q [2*PKT_LEN];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr, mem_raddr;
  logic            wr_sel_bank, rd_sel_bank;
  logic [IW-1:0]   wr_sel_idx, rd_sel_idx;
  logic            rd_en;
  logic            set_full, drop_ev;
  logic [1:0]      clr_full;
  logic [7:0]      wr_tag;
  logic            free_bank, have_free;
  logic [7:0]      out_byte;

  // Write side: hunt for sync, fill a free bank, qualify the packet on completion
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    tag_d       = tag_q;
    mem_we      = 1'b0;
    wr_sel_bank = wr_bank_q;
    wr_sel_idx  = wr_idx_q;
    set_full    = 1'b0;
    drop_ev     = 1'b0;
    free_bank   = full_q[0];
    have_free   = ~&full_q;
    wr_tag      = (wr_idx_q == TAG_IDX) ? DATA_IN : tag_q;

    if (D_VALID_IN) begin
      if (P_SYNC_IN) begin
        // an early sync aborts the current packet; the bank being filled is never full
        if (wr_state_q == W_FILL) drop_ev = 1'b1;
        if (have_free) begin
          mem_we      = 1'b1;
          wr_sel_bank = free_bank;
          wr_sel_idx  = '0;
          wr_bank_d   = free_bank;
          wr_idx_d    = IW'(1);
          tag_d       = (TAG_IDX == '0) ? DATA_IN : tag_q;
          wr_state_d  = W_FILL;
        end else begin
          drop_ev    = 1'b1;
          wr_state_d = W_HUNT;
        end
      end else if (wr_state_q == W_FILL) begin
        mem_we = 1'b1;
        if (wr_idx_q == TAG_IDX) tag_d = DATA_IN;
        if (wr_idx_q == LAST_IDX) begin
          wr_state_d = W_HUNT;
          if (wr_tag[7:2] == TAG_MAGIC && CH_EN[wr_tag[1:0]]) set_full = 1'b1;
          else drop_ev = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
    end
  end

  // Read side: the first byte is fetched on the IDLE->SEND cycle so a bank
  // completing while the other finishes is replayed with no idle gap
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    rd_en       = 1'b0;
    rd_sel_bank = rd_bank_q;
    rd_sel_idx  = rd_idx_q;
    clr_full    = '0;

    case (rd_state_q)
      R_IDLE: begin
        if (|full_q) begin
          rd_en       = 1'b1;
          rd_sel_bank = (&full_q) ? old_bank_q : full_q[1];
          rd_sel_idx  = '0;
          rd_bank_d   = rd_sel_bank;
          rd_idx_d    = IW'(1);
          rd_state_d  = R_SEND;
        end
      end
      R_SEND: begin
        rd_en = 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_idx_d            = '0;
          if (full_q[!rd_bank_q]) rd_bank_d = !rd_bank_q;
          else rd_state_d = R_IDLE;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    full_d     = full_q & ~clr_full;
    bank_ch_d  = bank_ch_q;
    old_bank_d = old_bank_q;
    if (set_full) begin
      full_d[wr_bank_q]    = 1'b1;
      bank_ch_d[wr_bank_q] = wr_tag[1:0];
      old_bank_d = (full_q[!wr_bank_q] && !clr_full[!wr_bank_q]) ? !wr_bank_q : wr_bank_q;
    end
    drop_cnt_d = (drop_ev && drop_cnt_q != '1) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_comb begin
    mem_waddr = wr_sel_bank ? AW'(PKT_LEN) + AW'(wr_sel_idx) : AW'(wr_sel_idx);
    mem_raddr = rd_sel_bank ? AW'(PKT_LEN) + AW'(rd_sel_idx) : AW'(rd_sel_idx);
  end

  always_comb begin
    s1_vld_d   = rd_en;
    s1_ch_d    = bank_ch_q[rd_sel_bank];
    s1_first_d = rd_en && (rd_sel_idx == '0);
    s1_tag_d   = rd_en && (rd_sel_idx == TAG_IDX);
  end

  always_comb begin
    out_byte   = s1_tag_q ? RESTORE_VAL : rd_data_q;
    data_out_d = '0;
    dvalid_d   = '0;
    psync_d    = '0;
    if (s1_vld_q) begin
      data_out_d[8*s1_ch_q +: 8] = out_byte;
      dvalid_d[s1_ch_q]          = 1'b1;
      psync_d[s1_ch_q]           = s1_first_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= DATA_IN;
    rd_data_q <= mem_q[mem_raddr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_state_q <= W_HUNT;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      tag_q      <= '0;
      full_q     <= '0;
      bank_ch_q  <= '0;
      old_bank_q <= 1'b0;
      drop_cnt_q <= '0;
      rd_state_q <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_first_q <= 1'b0;
      s1_tag_q   <= 1'b0;
      data_out_q <= '0;
      dvalid_q   <= '0;
      psync_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      tag_q      <= tag_d;
      full_q     <= full_d;
      bank_ch_q  <= bank_ch_d;
      old_bank_q <= old_bank_d;
      drop_cnt_q <= drop_cnt_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      s1_vld_q   <= s1_vld_d;
      s1_ch_q    <= s1_ch_d;
      s1_first_q <= s1_first_d;
      s1_tag_q   <= s1_tag_d;
      data_out_q <= data_out_d;
      dvalid_q   <= dvalid_d;
      psync_q    <= psync_d;
    end
  end

  assign DATA_OUT    = data_out_q;
  assign D_VALID_OUT = dvalid_q;
  assign P_SYNC_OUT  = psync_q;
  assign DROP_CNT    = drop_cnt_q;
  assign LOCKED      = (wr_state_q == W_FILL);

endmodule

// File: tb/tb_ts_demuxer.sv
// Directed bench for ts_demuxer: per-packet vector table plus hand sequences for
// back-to-back replay, early-sync abort and reset during replay.
module tb_ts_demuxer;

  localparam int PKT = 188;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        dv  = 1'b0;
  logic        ps  = 1'b0;
  logic [3:0]  ch_en = 4'hF;
  logic [31:0] data_out;
  logic [3:0]  dvalid_out, psync_out;
  logic [15:0] drop_cnt;
  logic        locked;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] data;
    bit         sync;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    logic [7:0]  tag;
    logic [3:0]  ch_en;
    bit          exp_out;
    int          exp_ch;
    logic [15:0] exp_drop;
  } vec_t;
  vec_t vecs[8];

  ts_demuxer dut (
    .CLK(clk), .RST(rst), .DATA_IN(din), .D_VALID_IN(dv), .P_SYNC_IN(ps),
    .CH_EN(ch_en), .DATA_OUT(data_out), .D_VALID_OUT(dvalid_out),
    .P_SYNC_OUT(psync_out), .DROP_CNT(drop_cnt), .LOCKED(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int nv, ch;
    logic ok;
    logic [31:0] mask;
    if (mon_en) begin
      nv = $countones(dvalid_out);
      ch = 0;
      for (int c = 0; c < 4; c++) if (dvalid_out[c]) ch = c;
      mask = 32'hFF << (8 * ch);
      if (nv == 0) ok = (data_out == 32'h0) && (psync_out == 4'h0);
      else ok = (nv == 1) && ((data_out & ~mask) == 32'h0) && ((psync_out & ~dvalid_out) == 4'h0);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL lane_iso cyc=%0d valid=%b sync=%b data=%h", cyc, dvalid_out, psync_out, data_out);
      end
      if (nv == 1) beats.push_back('{cyc, ch, data_out[8*ch +: 8], psync_out[ch]});
    end
  end

  function automatic logic [7:0] pbyte(input int seed, input int i, input logic [7:0] tag);
    if (i == 0) return tag;
    return 8'((seed * 37 + i * 11 + 5) & 255);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      dv = 1'b0;
      ps = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Leaves the last byte driven; the caller ticks to release the bus.
  task automatic send_pkt(input logic [7:0] tag, input int seed, input int nbytes,
                          input int gap_pct, output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < nbytes; i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) tick();
      @(negedge clk);
      din = pbyte(seed, i, tag);
      dv  = 1'b1;
      ps  = (i == 0);
      last_cyc = cyc;
    end
  endtask

  task automatic check_pkt(input int exp_ch, input int seed, input int exp_first,
                           output int first_c, output int last_c);
    int waited, bad_data, bad_ch, bad_sync, bad_gap;
    logic [7:0] e, got_bad, exp_bad;
    beat_t b;
    waited = 0; bad_data = 0; bad_ch = 0; bad_sync = 0; bad_gap = 0;
    got_bad = '0; exp_bad = '0;
    first_c = -1; last_c = -1;
    while (beats.size() < PKT && waited < 2000) begin
      tick();
      waited++;
    end
    checks++;
    if (beats.size() < PKT) begin
      failures++;
      $display("FAIL pkt_count got=%0d exp=%0d", beats.size(), PKT);
      beats.delete();
      return;
    end
    for (int i = 0; i < PKT; i++) begin
      b = beats.pop_front();
      if (i == 0) first_c = b.cyc;
      last_c = b.cyc;
      e = (i == 0) ? 8'h47 : pbyte(seed, i, 8'h00);
      if (b.data !== e) begin
        if (bad_data == 0) begin got_bad = b.data; exp_bad = e; end
        bad_data++;
      end
      if (b.ch != exp_ch) bad_ch++;
      if (b.sync != (i == 0)) bad_sync++;
      if (b.cyc != first_c + i) bad_gap++;
    end
    chk("pkt_channel_errs", bad_ch, 0);
    chk("pkt_sync_errs", bad_sync, 0);
    chk("pkt_gap_errs", bad_gap, 0);
    checks++;
    if (bad_data != 0) begin
      failures++;
      $display("FAIL pkt_data ch=%0d seed=%0d bad=%0d first got=%h exp=%h", exp_ch, seed, bad_data, got_bad, exp_bad);
    end
    if (exp_first >= 0) chk("latency_first_cyc", first_c, exp_first);
  endtask

  initial begin
    int last, f, l, prev_l, d0, waited;
    int lasts[8];

    vecs[0] = '{8'h45, 4'hF,    1'b1, 1, 16'd0};
    vecs[1] = '{8'h00, 4'hF,    1'b0, 0, 16'd1};
    vecs[2] = '{8'h46, 4'hF,    1'b1, 2, 16'd1};
    vecs[3] = '{8'h46, 4'b1011, 1'b0, 0, 16'd2};
    vecs[4] = '{8'h47, 4'b1011, 1'b1, 3, 16'd2};
    vecs[5] = '{8'h44, 4'b1011, 1'b1, 0, 16'd2};
    vecs[6] = '{8'hC5, 4'hF,    1'b0, 0, 16'd3};
    vecs[7] = '{8'h44, 4'b1110, 1'b0, 0, 16'd4};

    rst = 1'b1;
    tick(3);
    chk("rst_dvalid", dvalid_out, 0);
    chk("rst_psync", psync_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    for (int i = 0; i < 8; i++) begin
      ch_en = vecs[i].ch_en;
      send_pkt(vecs[i].tag, 10 + i, PKT, 0, last);
      tick();
      if (vecs[i].exp_out) begin
        check_pkt(vecs[i].exp_ch, 10 + i, last + 3, f, l);
      end else begin
        tick(200);
        chk("vec_no_output", beats.size(), 0);
      end
      tick(5);
      chk("vec_drop_cnt", drop_cnt, vecs[i].exp_drop);
    end

    ch_en = 4'hF;
    d0 = drop_cnt;
    for (int k = 0; k < 8; k++) send_pkt(8'h44 | 8'(k % 4), 100 + k, PKT, 0, lasts[k]);
    tick();
    prev_l = -1;
    for (int k = 0; k < 8; k++) begin
      check_pkt(k % 4, 100 + k, (k == 0) ? lasts[0] + 3 : -1, f, l);
      if (k > 0) chk("b2b_no_gap", f, prev_l + 1);
      prev_l = l;
    end
    tick(10);
    chk("b2b_drop_cnt", drop_cnt, d0);

    d0 = drop_cnt;
    send_pkt(8'h46, 200, 100, 0, last);
    chk("abort_locked_fill", locked, 1);
    send_pkt(8'h47, 201, PKT, 0, last);
    tick();
    chk("abort_locked_hunt", locked, 0);
    check_pkt(3, 201, last + 3, f, l);
    tick(250);
    chk("abort_leftover", beats.size(), 0);
    chk("abort_drop_cnt", drop_cnt, d0 + 1);

    send_pkt(8'h46, 300, PKT, 50, last);
    tick();
    waited = 0;
    while (beats.size() == 0 && waited < 2000) begin
      tick();
      waited++;
    end
    chk("rst_wait_send", beats.size() > 0, 1);
    tick(40);
    rst = 1'b1;
    tick();
    chk("midrst_dvalid", dvalid_out, 0);
    chk("midrst_psync", psync_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick(3);
    beats.delete();

    send_pkt(8'h47, 301, 60, 50, last);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    send_pkt(8'h44, 302, PKT, 50, last);
    tick();
    check_pkt(0, 302, last + 3, f, l);
    tick(250);
    chk("post_rst_leftover", beats.size(), 0);
    chk("post_rst_drop", drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
